// File: rtl/matrix_skew_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matrix_skew_feeder_pkg
// Description : Shared systolic constants and feeder state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package matrix_skew_feeder_pkg;

    localparam int c_def_width = 16;
    localparam int c_def_n     = 4;
    localparam int c_def_depth = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } feeder_state_t;

endpackage
`default_nettype wire

// File: rtl/matrix_skew_feeder_skew.sv
`default_nettype none
// ============================================================================
// Module      : skew_delay
// Description : DELAY-stage register chain carrying one row's data and valid.
// Revision    : 1.0 - initial release
// ============================================================================
module skew_delay #(
    parameter int WIDTH = 16,
    parameter int DELAY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);

    logic [WIDTH-1:0] r_data [DELAY];
    logic [DELAY-1:0] r_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DELAY; k++) begin
                r_data[k] <= '0;
            end
            r_valid <= '0;
        end else begin
            r_data[0]  <= i_data;
            r_valid[0] <= i_valid;
            for (int k = 1; k < DELAY; k++) begin
                r_data[k]  <= r_data[k-1];
                r_valid[k] <= r_valid[k-1];
            end
        end
    end

    assign o_data  = r_data[DELAY-1];
    assign o_valid = r_valid[DELAY-1];

endmodule
`default_nettype wire

// File: rtl/matrix_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module      : matrix_skew_feeder
// Description : Buffers activation vectors and feeds them diagonally skewed
//               into the left edge of an N-row systolic array.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_skew_feeder
    import matrix_skew_feeder_pkg::*;
#(
    parameter int WIDTH = c_def_width,
    parameter int N     = c_def_n,
    parameter int DEPTH = c_def_depth
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [N*WIDTH-1:0] s_data,
    input  logic               s_last,
    output logic [N*WIDTH-1:0] out_left,
    output logic [N-1:0]       out_valid,
    output logic               busy,
    output logic               done
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam int c_drn_w = (N > 1) ? $clog2(N) : 1;

    logic [N*WIDTH-1:0] r_mem_data [DEPTH];
    logic [DEPTH-1:0]   r_mem_last;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    feeder_state_t      r_state;
    logic [c_drn_w-1:0] r_drain_cnt;
    logic               r_busy;
    logic               r_done;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_pop_last;
    logic [N*WIDTH-1:0] w_inj_data;

    assign w_full     = (r_count == c_cnt_w'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_push     = s_valid && !w_full;
    assign w_pop      = (r_state == STREAM) && !w_empty;
    assign w_pop_last = w_pop && r_mem_last[r_rd_ptr];
    // Anything not popped is a bubble: zero data, valid low.
    assign w_inj_data = w_pop ? r_mem_data[r_rd_ptr] : '0;

    assign s_ready = !w_full;
    assign busy    = r_busy;
    assign done    = r_done;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= s_data;
            r_mem_last[r_wr_ptr] <= s_last;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_ptr_w'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_ptr_w'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_drain_cnt <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_state <= STREAM;
                        r_busy  <= 1'b1;
                    end
                end
                STREAM: begin
                    if (w_pop_last) begin
                        if (N > 1) begin
                            r_state     <= DRAIN;
                            r_drain_cnt <= c_drn_w'(N - 1);
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // N-1 bubble cycles push the last diagonal out to row N-1.
                    if (r_drain_cnt == c_drn_w'(1)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        skew_delay #(
            .WIDTH (WIDTH),
            .DELAY (gi + 1)
        ) u_skew (
            .clk     (clk),
            .rst     (rst),
            .i_data  (w_inj_data[gi*WIDTH +: WIDTH]),
            .i_valid (w_pop),
            .o_data  (out_left[gi*WIDTH +: WIDTH]),
            .o_valid (out_valid[gi])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_skew_feeder
// Description : Scoreboard bench: accepted vectors are expected on row i
//               exactly i cycles after they appear on row 0.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_matrix_skew_feeder;

    localparam int WIDTH = 16;
    localparam int N     = 4;
    localparam int DEPTH = 4;

    typedef logic [N*WIDTH-1:0] vec_t;
    typedef struct { vec_t data; bit last; } vec_ent_t;
    typedef struct { int due; logic [WIDTH-1:0] data; bit last; } lane_ent_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_last = 1'b0;
    vec_t         s_data = '0;
    logic         s_ready;
    vec_t         out_left;
    logic [N-1:0] out_valid;
    logic         busy;
    logic         done;

    int        n_cmp = 0;
    int        n_bad = 0;
    vec_ent_t  exp_q [$];
    lane_ent_t lane_q [N][$];
    int        acc_cnt = 0;
    int        pop_cnt = 0;
    int        batches = 0;
    int        dones = 0;
    int        cyc = 0;
    int        full_seen = 0;
    int        gap_run = 0;
    bit        after_last = 1'b0;
    bit        mon_en = 1'b0;

    matrix_skew_feeder #(.WIDTH(WIDTH), .N(N), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .out_left  (out_left),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sx(input logic [WIDTH-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic vec_t mk(input int a, input int b, input int c, input int d);
        vec_t v;
        v[0*WIDTH +: WIDTH] = WIDTH'(a);
        v[1*WIDTH +: WIDTH] = WIDTH'(b);
        v[2*WIDTH +: WIDTH] = WIDTH'(c);
        v[3*WIDTH +: WIDTH] = WIDTH'(d);
        return v;
    endfunction

    function automatic vec_t rvec();
        vec_t v;
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 5))
                0:       v[i*WIDTH +: WIDTH] = {1'b1, {(WIDTH-1){1'b0}}};
                1:       v[i*WIDTH +: WIDTH] = {1'b0, {(WIDTH-1){1'b1}}};
                default: v[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            endcase
        end
        return v;
    endfunction

    function automatic bit lanes_empty();
        for (int i = 0; i < N; i++) begin
            if (lane_q[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        vec_ent_t  e;
        lane_ent_t le;
        bit        exp_done;
        if (mon_en) begin
            exp_done = 1'b0;
            cyc++;
            if (out_valid[0]) begin
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    chk("row0_unexpected_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("row0_data", sx(out_left[0 +: WIDTH]), sx(e.data[0 +: WIDTH]));
                    if (after_last) chk("drain_bubbles_ge_n_minus_1", longint'(gap_run >= N-1), 1);
                    after_last = e.last;
                    gap_run = 0;
                    for (int i = 1; i < N; i++) begin
                        lane_q[i].push_back('{cyc + i, e.data[i*WIDTH +: WIDTH], e.last});
                    end
                end
            end else begin
                chk("row0_bubble_zero", sx(out_left[0 +: WIDTH]), 0);
                gap_run++;
            end
            for (int i = 1; i < N; i++) begin
                if (lane_q[i].size() != 0 && lane_q[i][0].due < cyc) begin
                    le = lane_q[i].pop_front();
                    chk($sformatf("row%0d_missed_cycle", i), longint'(cyc), longint'(le.due));
                end
                if (lane_q[i].size() != 0 && lane_q[i][0].due == cyc) begin
                    le = lane_q[i].pop_front();
                    chk($sformatf("row%0d_valid", i), longint'(out_valid[i]), 1);
                    chk($sformatf("row%0d_data", i), sx(out_left[i*WIDTH +: WIDTH]), sx(le.data));
                    if (i == N-1 && le.last) exp_done = 1'b1;
                end else begin
                    chk($sformatf("row%0d_bubble_valid", i), longint'(out_valid[i]), 0);
                    chk($sformatf("row%0d_bubble_zero", i), sx(out_left[i*WIDTH +: WIDTH]), 0);
                end
            end
            chk("done", longint'(done), longint'(exp_done));
            if (done) begin
                dones++;
                chk("busy_low_with_done", longint'(busy), 0);
            end
            chk("s_ready", longint'(s_ready), longint'((acc_cnt - pop_cnt) < DEPTH));
            if (!s_ready) full_seen++;
        end
    end

    task automatic push(input vec_t d, input bit last);
        int tries;
        tries = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        forever begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk);
                exp_q.push_back('{d, last});
                acc_cnt++;
                if (last) batches++;
                #1;
                s_valid = 1'b0;
                s_data  = '0;
                s_last  = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
            tries++;
            if (tries > 200) begin
                chk("push_accept_timeout", longint'(tries), 0);
                s_valid = 1'b0;
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_out_left"}, longint'(out_left != '0), 0);
        chk({tag, "_out_valid"}, longint'(out_valid), 0);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_done"}, longint'(done), 0);
        chk({tag, "_s_ready"}, longint'(s_ready), 1);
    endtask

    initial begin
        int len;
        repeat (3) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Single vector batch
        push(mk(1, 2, 3, 4), 1'b1);
        idle(12);

        // Four back-to-back vectors, last on the fourth
        for (int k = 0; k < 4; k++) push(mk(10*k+1, 10*k+2, 10*k+3, 10*k+4), k == 3);
        idle(12);

        // Signed extremes
        push(mk(-32768, 32767, -32768, 32767), 1'b0);
        push(mk(32767, -32768, -1, 0), 1'b1);
        idle(12);

        // Pushes during drain fill the FIFO
        full_seen = 0;
        push(rvec(), 1'b1);
        for (int k = 0; k < 6; k++) push(rvec(), k == 5);
        chk("fifo_full_reached", longint'(full_seen > 0), 1);
        idle(15);

        // Random batches with gaps in s_valid
        for (int b = 0; b < 6; b++) begin
            len = int'($urandom_range(1, 6));
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
                push(rvec(), k == len-1);
            end
            if ($urandom_range(0, 1) == 0) idle(int'($urandom_range(1, 8)));
        end
        idle(20);

        // Reset during STREAM with entries still buffered
        push(rvec(), 1'b1);
        for (int k = 0; k < 4; k++) push(rvec(), 1'b0);
        idle(3);
        chk("pre_reset_busy", longint'(busy), 1);
        mon_en = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk_zero_outputs("midreset");
        exp_q.delete();
        for (int i = 0; i < N; i++) lane_q[i].delete();
        acc_cnt = 0;
        pop_cnt = 0;
        gap_run = 0;
        after_last = 1'b0;
        batches = dones;
        repeat (2) begin
            @(negedge clk);
            chk("in_reset_done", longint'(done), 0);
            chk("in_reset_valid", longint'(out_valid), 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        mon_en = 1'b1;
        for (int k = 0; k < 3; k++) push(rvec(), k == 2);
        idle(4);

        for (int t = 0; t < 300; t++) begin
            if (exp_q.size() == 0 && lanes_empty() && dones == batches) break;
            @(posedge clk);
        end
        #1;
        chk("final_pending_vectors", longint'(exp_q.size()), 0);
        chk("final_pending_lanes", longint'(!lanes_empty()), 0);
        chk("final_done_count", longint'(dones), longint'(batches));
        @(negedge clk);
        chk("final_busy", longint'(busy), 0);
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/matrix_skew_feeder.md
MATRIX_SKEW_FEEDER -- requirements
Module: matrix_skew_feeder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, signed element width.
REQ-002 SHALL have parameter N, default 4, array rows (one skew lane per row).
REQ-003 SHALL have parameter DEPTH, default 8, input FIFO depth in vectors (power of two).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port s_valid  input  1  upstream vector valid.
REQ-007 SHALL have port s_ready  output  1  feeder can accept a vector.
REQ-008 SHALL have port s_data  input  N x WIDTH signed  one activation per row.
REQ-009 SHALL have port s_last  input  1  marks final vector of a batch.
REQ-010 SHALL have port out_left  output  N x WIDTH signed  skewed row data to array left edge.
REQ-011 SHALL have port out_valid  output  N  per-row flag, element is real data (not bubble).
REQ-012 SHALL have port busy  output  1  batch in flight (state not IDLE).
REQ-013 SHALL have port done  output  1  one-cycle pulse after batch fully drained.

Function
REQ-014 SHALL accept a vector when s_valid and s_ready are both high on a clock edge; s_ready = FIFO not full, no same-cycle pass-through when full.
REQ-015 SHALL store s_data and s_last together per FIFO entry; wrap-around of read/write pointers modulo DEPTH with separate count for full/empty.
REQ-016 SHALL implement FSM states IDLE, STREAM, DRAIN.
REQ-017 IDLE -> STREAM when FIFO non-empty; busy low only in IDLE.
REQ-018 In STREAM, each cycle SHALL pop one vector if FIFO non-empty, else inject an all-zero bubble vector (valid bits 0).
REQ-019 STREAM -> DRAIN on the cycle a popped entry carries s_last; DRAIN SHALL inject exactly N-1 bubble vectors, then pulse done for one cycle and return to IDLE.
REQ-020 Row i SHALL be delayed 1+i cycles from pop: out_left[0] registered once, out_left[i] through i additional registers; out_valid[i] travels with its data.
REQ-021 Bubble lanes SHALL drive out_left[i] = 0 so array accumulators see zero.
REQ-022 Pushes SHALL continue to be accepted during DRAIN and DONE; entries of the next batch wait until IDLE -> STREAM.
REQ-023 Simultaneous push and pop SHALL leave count unchanged.
REQ-024 No arithmetic on data; values pass bit-exact.

Reset
REQ-025 rst low SHALL asynchronously clear FIFO pointers/count, all skew registers, out_left = 0, out_valid = 0, done = 0, busy = 0, state = IDLE; s_ready = 1 after reset.
REQ-026 Reset mid-batch SHALL discard all buffered and in-flight data without a done pulse.

Structure
REQ-027 State enum (IDLE, STREAM, DRAIN) and default N/WIDTH constants SHALL live in the shared systolic package.
REQ-028 The per-row delay line SHALL be a sub-module skew_delay (parameters WIDTH, DELAY), instantiated N times in a generate loop.

Verification
REQ-029 Single vector {1,2,3,4} with s_last -> out_left[i]=i+1 with out_valid[i] at cycle 1+i after pop; done at pop+N+... after drain; busy falls with done.
REQ-030 Four back-to-back vectors, last on fourth -> row 3 shows first element 4 cycles after first pop, all four contiguous, N-1 bubble cycles, one done pulse.
REQ-031 Push DEPTH vectors while stalled in reset-release-then-blocked scenario -> s_ready low at count DEPTH, ninth push not accepted, order preserved.
REQ-032 Gap in s_valid mid-batch -> zero bubble with out_valid 0 on affected diagonal, no done until s_last drains.
REQ-033 rst asserted during STREAM with 3 entries buffered -> all outputs 0 immediately, no done, s_ready 1, new batch streams correctly.
REQ-034 Values -32768 and 32767 -> reproduced bit-exact on outputs.
